// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-draining UART transmitter: FSM state encoding,
// the single-bit alias and the default baud divisor.
package fifo_uart_tx_pkg;

    typedef logic bit_t;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        STOP
    } tx_state_t;

    // 50 MHz / 115200 baud
    localparam int UART_BAUD_DIV_DEFAULT = 434;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts BAUD_DIV cycles and pulses tick on the last one.
// clear holds it at zero so every bit period starts from a full count.
module uart_baud_counter
    import fifo_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
    input  logic uart_clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             terminal;

    assign terminal = (cnt_reg == LAST_CNT);
    assign tick     = !clear && terminal;

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clear || terminal) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one word when allowed and sends it as an
// 8N1-style frame (start, LSB-first data, stop) on tx.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT
) (
    input  logic                  uart_clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] dataoutput,
    output logic                  pop,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] data_shift_next;
    logic [BIT_W-1:0]      bit_cnt_reg;
    bit_t                  tx_reg;
    logic                  can_start;
    logic                  baud_clear;
    logic                  baud_tick;

    assign can_start       = tx_en && !empty;
    assign data_shift_next = data_reg >> 1;

    // Only the serial phases are timed; the counter sits at zero otherwise.
    assign baud_clear = (state_reg == IDLE) || (state_reg == POP) || (state_reg == WAIT);

    uart_baud_counter #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .uart_clk(uart_clk),
        .reset   (reset),
        .clear   (baud_clear),
        .tick    (baud_tick)
    );

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            data_reg    <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (can_start) begin
                        state_reg <= POP;
                    end
                end
                POP: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // FIFO read data is valid now, one cycle after the pop strobe.
                    data_reg  <= dataoutput;
                    tx_reg    <= 1'b0;
                    state_reg <= START;
                end
                START: begin
                    if (baud_tick) begin
                        tx_reg      <= data_reg[0];
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            tx_reg      <= 1'b1;
                            bit_cnt_reg <= '0;
                            state_reg   <= STOP;
                        end else begin
                            data_reg    <= data_shift_next;
                            tx_reg      <= data_shift_next[0];
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    // empty/tx_en are looked at again only on the last stop cycle.
                    if (baud_tick) begin
                        state_reg <= can_start ? POP : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign pop  = (state_reg == POP);
    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx (DATA_WIDTH=8, BAUD_DIV=4): a FIFO model feeds the
// DUT, expected frames are queued at stimulus time and a tx monitor checks them.
module tb_fifo_uart_tx;

    logic       uart_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_en    = 1'b0;
    logic       empty;
    logic [7:0] dataoutput = 8'h00;
    logic       pop;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] fifo_q[$];
    int         fifo_cnt    = 0;
    logic       block_empty = 1'b0;
    logic [9:0] exp_q[$];
    int         pop_cnt  = 0;
    int         busy_cnt = 0;
    int         pop_times[$];

    assign empty = (fifo_cnt == 0) || block_empty;

    fifo_uart_tx #(
        .DATA_WIDTH(8),
        .BAUD_DIV  (4)
    ) dut (
        .uart_clk  (uart_clk),
        .reset     (reset),
        .tx_en     (tx_en),
        .empty     (empty),
        .dataoutput(dataoutput),
        .pop       (pop),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push_fifo(input logic [7:0] w);
        fifo_q.push_back(w);
        fifo_cnt++;
    endtask

    task automatic push_exp(input logic [9:0] f);
        exp_q.push_back(f);
    endtask

    task automatic wait_busy(input logic level, input int limit, input string name);
        int n = 0;
        while (busy !== level && n < limit) begin
            @(negedge uart_clk);
            n++;
        end
        check(name, busy, level);
    endtask

    task automatic reset_on();
        reset       = 1'b1;
        fifo_q.delete();
        fifo_cnt    = 0;
        block_empty = 1'b0;
        exp_q.delete();
        pop_cnt     = 0;
        busy_cnt    = 0;
        pop_times.delete();
        repeat (2) @(negedge uart_clk);
        check("rst_tx", tx, 1);
        check("rst_pop", pop, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic reset_off();
        @(posedge uart_clk);
        #1 reset = 1'b0;
    endtask

    initial forever @(posedge uart_clk) cyc++;

    // FIFO model and activity counters, all updated away from the active edge.
    initial forever begin
        @(negedge uart_clk);
        if (busy === 1'b1) busy_cnt++;
        if (pop === 1'b1) begin
            pop_cnt++;
            pop_times.push_back(cyc);
            check("pop_while_empty", empty, 0);
            if (fifo_cnt > 0) begin
                dataoutput = fifo_q.pop_front();
                fifo_cnt--;
            end
        end
    end

    // tx monitor: captures 40 cycles from each start bit and compares to the queue.
    initial begin
        logic [39:0] cap;
        logic [39:0] e40;
        logic [9:0]  e;
        int          n;
        bit          in_frame;
        int          frames;
        in_frame = 0;
        n        = 0;
        frames   = 0;
        cap      = '0;
        forever begin
            @(negedge uart_clk);
            if (reset === 1'b1) begin
                in_frame = 0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1;
                    cap      = '0;
                    n        = 1;
                end
            end else begin
                cap[n] = tx;
                n++;
                if (n == 40) begin
                    in_frame = 0;
                    frames++;
                    check("frame_was_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < 40; i++) e40[i] = e[i/4];
                        check("frame_bits", cap, e40);
                        $display("frame %0d: expected bits %b (start first = LSB)", frames, e);
                    end
                end
            end
        end
    end

    initial begin
        int viol;

        reset_on();
        reset_off();

        // 1: empty FIFO with tx_en high stays idle
        tx_en = 1'b1;
        viol  = 0;
        repeat (30) begin
            @(negedge uart_clk);
            if (tx !== 1'b1 || pop !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("s1_idle_violations", viol, 0);

        // 2: single word 0xA5
        reset_on();
        reset_off();
        push_fifo(8'hA5);
        push_exp(10'b1101001010);
        wait_busy(1'b1, 20, "s2_busy_rise");
        wait_busy(1'b0, 200, "s2_busy_fall");
        check("s2_pops", pop_cnt, 1);
        check("s2_busy_cycles", busy_cnt, 42);
        check("s2_frames_left", exp_q.size(), 0);

        // 3: back-to-back 0x00 then 0xFF (pushed while reset is held)
        reset_on();
        push_fifo(8'h00);
        push_exp(10'b1000000000);
        push_fifo(8'hFF);
        push_exp(10'b1111111110);
        reset_off();
        wait_busy(1'b1, 20, "s3_busy_rise");
        wait_busy(1'b0, 300, "s3_busy_fall");
        check("s3_pops", pop_cnt, 2);
        check("s3_busy_cycles", busy_cnt, 84);
        if (pop_times.size() >= 2) check("s3_pop_spacing", pop_times[1] - pop_times[0], 42);
        check("s3_frames_left", exp_q.size(), 0);

        // 4: tx_en dropped during data bits of 0x3C, second word must stay queued
        reset_on();
        push_fifo(8'h3C);
        push_exp(10'b1001111000);
        push_fifo(8'h77);
        reset_off();
        wait_busy(1'b1, 20, "s4_busy_rise");
        repeat (12) @(negedge uart_clk);
        tx_en = 1'b0;
        wait_busy(1'b0, 200, "s4_busy_fall");
        check("s4_pops", pop_cnt, 1);
        check("s4_busy_cycles", busy_cnt, 42);
        check("s4_fifo_left", fifo_cnt, 1);
        repeat (10) @(negedge uart_clk);
        check("s4_idle_busy", busy, 0);
        check("s4_idle_tx", tx, 1);
        check("s4_no_more_pops", pop_cnt, 1);
        check("s4_frames_left", exp_q.size(), 0);

        // 5: reset in the middle of data bit 2 (a zero) of 0x5A
        tx_en = 1'b1;
        reset_on();
        push_fifo(8'h5A);
        reset_off();
        wait_busy(1'b1, 20, "s5_busy_rise");
        repeat (15) @(negedge uart_clk);
        check("s5_tx_before_reset", tx, 0);
        #1 reset = 1'b1;
        #1;
        check("s5_async_tx", tx, 1);
        check("s5_async_busy", busy, 0);
        reset_on();
        push_fifo(8'h81);
        push_exp(10'b1100000010);
        repeat (2) @(negedge uart_clk);
        check("s5_reset_wins_busy", busy, 0);
        check("s5_reset_wins_pops", pop_cnt, 0);
        reset_off();
        wait_busy(1'b1, 20, "s5_busy_rise2");
        wait_busy(1'b0, 200, "s5_busy_fall2");
        check("s5_pops", pop_cnt, 1);
        check("s5_busy_cycles", busy_cnt, 42);
        check("s5_frames_left", exp_q.size(), 0);

        // 6: a word arrives mid-frame, empty rises during STOP of 0x12
        reset_on();
        push_fifo(8'h12);
        push_exp(10'b1000100100);
        reset_off();
        wait_busy(1'b1, 20, "s6_busy_rise");
        repeat (20) @(negedge uart_clk);
        push_fifo(8'h34);
        repeat (19) @(negedge uart_clk);
        block_empty = 1'b1;
        wait_busy(1'b0, 100, "s6_busy_fall");
        check("s6_pops", pop_cnt, 1);
        check("s6_busy_cycles", busy_cnt, 42);
        check("s6_fifo_left", fifo_cnt, 1);
        viol = 0;
        repeat (10) begin
            @(negedge uart_clk);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("s6_idle_violations", viol, 0);
        check("s6_no_more_pops", pop_cnt, 1);
        check("s6_frames_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
